face_display_scheduler: RTL and testbench

- Owns the two-digit 7-segment display and shares it between the live score digits and the face patterns (eyes, mouth) from the face generator.
- Turns single-cycle event pulses (died, newHighScore) into timed face showings, with priority and one-deep queuing.
- Returns the display to the score after each showing.
- Sits between game control, the face generator and the display driver.

---
 rtl/face_display_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_face_display_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/face_display_scheduler.sv
// Shares the two-digit 7-segment display between the score and timed face showings.
// Optional FACE_BLINK_EN macro makes faces blink (show/blank phases of BLINK_CYCLES).
module face_display_scheduler #(
    parameter int HOLD_CYCLES  = 50,
    parameter int BLINK_CYCLES = 10,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newHighScore,
    input  logic       died,
    input  logic [6:0] eyes,
    input  logic [6:0] mouth,
    input  logic [6:0] scoreTens,
    input  logic [6:0] scoreOnes,
    output logic [6:0] segLeft,
    output logic [6:0] segRight,
    output logic       faceActive,
    output logic       faceKind,
    output logic       hsPending
);

    typedef enum logic [1:0] {
        SCORE     = 2'd0,
        FACE_HS   = 2'd1,
        FACE_DIED = 2'd2
    } state_t;

    localparam logic [6:0]       BLANK     = 7'h7F;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 2");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
        $error("BLINK_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hs_pending_q, hs_pending_d;
    logic [6:0]       seg_left_q, seg_left_d;
    logic [6:0]       seg_right_q, seg_right_d;
    logic             face_active_q, face_active_d;
    logic             face_kind_q, face_kind_d;
    logic             reload;
    logic             face_on;
    logic             show_face;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        hs_pending_d = hs_pending_q;
        reload       = 1'b0;
        case (state_q)
            SCORE: begin
                if (died) begin
                    state_d      = FACE_DIED;
                    reload       = 1'b1;
                    hs_pending_d = newHighScore;
                end else if (newHighScore) begin
                    state_d = FACE_HS;
                    reload  = 1'b1;
                end
            end
            FACE_DIED: begin
                if (newHighScore) hs_pending_d = 1'b1;
                if (died) begin
                    reload = 1'b1;
                end else if (hold_cnt_q == '0) begin
                    // a high score arriving on the final cycle still chains straight in
                    if (hs_pending_q || newHighScore) begin
                        state_d      = FACE_HS;
                        reload       = 1'b1;
                        hs_pending_d = 1'b0;
                    end else begin
                        state_d = SCORE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_ONE;
                end
            end
            FACE_HS: begin
                if (died) begin
                    state_d      = FACE_DIED;
                    reload       = 1'b1;
                    hs_pending_d = 1'b1;
                end else if (newHighScore) begin
                    reload = 1'b1;
                end else if (hold_cnt_q == '0) begin
                    state_d = SCORE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_ONE;
                end
            end
            default: state_d = SCORE;
        endcase
        if (reload) hold_cnt_d = HOLD_LOAD;
    end

    assign face_on = (state_d != SCORE);

`ifdef FACE_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_show_q, blink_show_d;

    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        blink_show_d = blink_show_q;
        if (reload) begin
            blink_cnt_d  = BLINK_LOAD;
            blink_show_d = 1'b1;
        end else if (face_on) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_d  = BLINK_LOAD;
                blink_show_d = !blink_show_q;
            end else begin
                blink_cnt_d = blink_cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q  <= '0;
            blink_show_q <= 1'b1;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            blink_show_q <= blink_show_d;
        end
    end

    assign show_face = blink_show_d;
`else
    assign show_face = 1'b1;
`endif

    // outputs follow the next state so every change lands one cycle after its cause
    always_comb begin
        seg_left_d    = scoreTens;
        seg_right_d   = scoreOnes;
        face_active_d = face_on;
        face_kind_d   = face_kind_q;
        if (face_on) begin
            seg_left_d  = show_face ? eyes  : BLANK;
            seg_right_d = show_face ? mouth : BLANK;
            face_kind_d = (state_d == FACE_DIED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCORE;
            hold_cnt_q    <= '0;
            hs_pending_q  <= 1'b0;
            seg_left_q    <= BLANK;
            seg_right_q   <= BLANK;
            face_active_q <= 1'b0;
            face_kind_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            hs_pending_q  <= hs_pending_d;
            seg_left_q    <= seg_left_d;
            seg_right_q   <= seg_right_d;
            face_active_q <= face_active_d;
            face_kind_q   <= face_kind_d;
        end
    end

    assign segLeft    = seg_left_q;
    assign segRight   = seg_right_q;
    assign faceActive = face_active_q;
    assign faceKind   = face_kind_q;
    assign hsPending  = hs_pending_q;

endmodule

// File: tb/tb_face_display_scheduler.sv
// Directed bench for face_display_scheduler with HOLD_CYCLES=8, BLINK_CYCLES=2.
module tb_face_display_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       newHighScore;
    logic       died;
    logic [6:0] eyes, mouth, scoreTens, scoreOnes;
    logic [6:0] segLeft, segRight;
    logic       faceActive, faceKind, hsPending;

    int n_cmp = 0;
    int n_err = 0;

    face_display_scheduler #(.HOLD_CYCLES(8), .BLINK_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .newHighScore(newHighScore), .died(died),
        .eyes(eyes), .mouth(mouth), .scoreTens(scoreTens), .scoreOnes(scoreOnes),
        .segLeft(segLeft), .segRight(segRight), .faceActive(faceActive),
        .faceKind(faceKind), .hsPending(hsPending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_score(input string tag);
        chk({tag, ".left"}, segLeft, 7'h30);
        chk({tag, ".right"}, segRight, 7'h24);
        chk({tag, ".active"}, {6'd0, faceActive}, 7'd0);
    endtask

    task automatic chk_face(input string tag, input logic kind, input logic pend);
        chk({tag, ".active"}, {6'd0, faceActive}, 7'd1);
        chk({tag, ".kind"}, {6'd0, faceKind}, {6'd0, kind});
        chk({tag, ".pend"}, {6'd0, hsPending}, {6'd0, pend});
    endtask

    initial begin
        rst = 1'b1; newHighScore = 1'b0; died = 1'b0;
        eyes = 7'h01; mouth = 7'h40; scoreTens = 7'h30; scoreOnes = 7'h24;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.left", segLeft, 7'h7F);
        chk("rst.right", segRight, 7'h7F);
        chk("rst.active", {6'd0, faceActive}, 7'd0);
        chk("rst.kind", {6'd0, faceKind}, 7'd0);
        chk("rst.pend", {6'd0, hsPending}, 7'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_score("idle");

        // single high-score showing
        newHighScore = 1'b1;
        @(negedge clk);
        newHighScore = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef FACE_BLINK_EN
            chk("hs.left", segLeft, ((i / 2) % 2 == 0) ? 7'h01 : 7'h7F);
            chk("hs.right", segRight, ((i / 2) % 2 == 0) ? 7'h40 : 7'h7F);
`else
            chk("hs.left", segLeft, 7'h01);
            chk("hs.right", segRight, 7'h40);
`endif
            chk_face("hs", 1'b0, 1'b0);
            @(negedge clk);
        end
        chk_score("hs.end");

        // died and high score together: died face, then chained HS face
        died = 1'b1; newHighScore = 1'b1;
        @(negedge clk);
        died = 1'b0; newHighScore = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_face("both.died", 1'b1, 1'b1);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            chk_face("both.hs", 1'b0, 1'b0);
            @(negedge clk);
        end
        chk_score("both.end");

        // died preempts an HS showing on its 5th cycle
        newHighScore = 1'b1;
        @(negedge clk);
        newHighScore = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_face("pre.hs", 1'b0, 1'b0);
            @(negedge clk);
        end
        chk_face("pre.hs5", 1'b0, 1'b0);
        died = 1'b1;
        @(negedge clk);
        died = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_face("pre.died", 1'b1, 1'b1);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            chk_face("pre.rehs", 1'b0, 1'b0);
            @(negedge clk);
        end
        chk_score("pre.end");

        // died on the final HS cycle still counts
        newHighScore = 1'b1;
        @(negedge clk);
        newHighScore = 1'b0;
        repeat (7) @(negedge clk);
        chk_face("last.hs8", 1'b0, 1'b0);
        died = 1'b1;
        @(negedge clk);
        died = 1'b0;
        chk_face("last.died", 1'b1, 1'b1);
        repeat (16) @(negedge clk);
        chk_score("last.end");

        // reset mid died showing with a queued HS
        died = 1'b1; newHighScore = 1'b1;
        @(negedge clk);
        died = 1'b0; newHighScore = 1'b0;
        chk_face("rd.c1", 1'b1, 1'b1);
        @(negedge clk);
        chk_face("rd.c2", 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rd.left", segLeft, 7'h7F);
        chk("rd.right", segRight, 7'h7F);
        chk("rd.active", {6'd0, faceActive}, 7'd0);
        chk("rd.kind", {6'd0, faceKind}, 7'd0);
        chk("rd.pend", {6'd0, hsPending}, 7'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_score("rd.after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
